dmem_arbiter: RTL

- Shares one single-port synchronous memory between three requesters: instruction fetch reads, execute-stage load reads, and retire-stage store writes.
- Buffers committed stores from retire in a small FIFO so retire never waits on memory.
- Blocks loads that hit a buffered store, and guarantees fetch forward progress with a starvation counter.
- Sits between the pipeline stages and the memory macro; the macro has 1-cycle read latency.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_store_fifo.sv | 70 +++++++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_FETCH,
        ARB_LOAD,
        ARB_STORE
    } arb_src_t;

    localparam int DMEM_STORE_DEPTH  = 2;
    localparam int DMEM_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arbiter_store_fifo.sv
// Committed-store buffer: circular FIFO of {addr, data, be} that also exposes
// every live entry's word address so loads can be checked against pending stores.
module dmem_arbiter_store_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [31:0]               push_addr,
    input  logic [31:0]               push_data,
    input  logic [3:0]                push_be,
    output logic [31:0]               head_addr,
    output logic [31:0]               head_data,
    output logic [3:0]                head_be,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH*30-1:0]       ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers, occupancy and per-entry valid bits. A push never targets the
    // entry being popped: push is refused when full, and pop needs count != 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            be_q[wr_ptr]   <= push_be;
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_be   = be_q[rd_ptr];

    always_comb begin
        ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i*30 +: 30] = addr_q[i][31:2];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory between fetch reads,
// load reads and buffered retire stores, with fetch starvation protection.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STORE_DEPTH  = DMEM_STORE_DEPTH,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_kill,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_full,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STORE_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]             count;
    logic [31:0]               head_addr;
    logic [31:0]               head_data;
    logic [3:0]                head_be;
    logic [STORE_DEPTH-1:0]    ent_valid;
    logic [STORE_DEPTH*30-1:0] ent_addr;
    logic                      st_push;
    logic                      ld_hazard;
    arb_src_t                  sel;
    arb_src_t                  rsp_src;
    logic                      kill_pend;
    logic [SW-1:0]             starve_cnt;

    assign st_full = (count == CW'(STORE_DEPTH));
    assign st_push = st_req && !st_full;

    dmem_arbiter_store_fifo #(
        .DEPTH(STORE_DEPTH)
    ) u_store_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (st_push),
        .pop       (sel == ARB_STORE),
        .push_addr (st_addr),
        .push_data (st_data),
        .push_be   (st_be),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_be   (head_be),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    // A store arriving this cycle is older than the load, so it counts too.
    always_comb begin
        ld_hazard = st_req && (st_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < STORE_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i*30 +: 30] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        sel = ARB_NONE;
        if (!reset) begin
            if (fetch_req && (starve_cnt == SW'(STARVE_LIMIT))) begin
                sel = ARB_FETCH;
            end else if (ld_req && !ld_hazard && !st_full) begin
                sel = ARB_LOAD;
            end else if (count != '0) begin
                sel = ARB_STORE;
            end else if (fetch_req) begin
                sel = ARB_FETCH;
            end
        end
    end

    assign fetch_gnt = (sel == ARB_FETCH);
    assign ld_gnt    = (sel == ARB_LOAD);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (sel)
            ARB_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
            end
            ARB_LOAD: begin
                mem_en   = 1'b1;
                mem_addr = ld_addr;
            end
            ARB_STORE: begin
                mem_en    = 1'b1;
                mem_we    = head_be;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: ;
        endcase
    end

    // Issue -> response stage boundary: remember who owns next cycle's rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_src    <= ARB_NONE;
            kill_pend  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            rsp_src   <= (sel == ARB_FETCH || sel == ARB_LOAD) ? sel : ARB_NONE;
            kill_pend <= fetch_gnt && fetch_kill;
            if (fetch_req && !fetch_gnt) begin
                if (starve_cnt != SW'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign fetch_valid = !reset && (rsp_src == ARB_FETCH) && !kill_pend && !fetch_kill;
    assign ld_valid    = !reset && (rsp_src == ARB_LOAD);
    assign fetch_data  = fetch_valid ? mem_rdata : '0;
    assign ld_data     = ld_valid ? mem_rdata : '0;

endmodule
